// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a tx_data/tx_start/tx_busy handshake.
// Latency: a write into an empty FIFO with tx_busy low produces tx_start two cycles later (pop, then LOAD).
// Backpressure: writes while full are dropped and flagged in the sticky overflow bit; pops wait for tx_busy low.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   wr_data, wr_en    byte to enqueue and its enqueue strobe
//   flush             synchronous clear of FIFO contents and overflow
//   full, empty       registered occupancy flags
//   count             registered occupancy, 0..DEPTH
//   overflow          sticky: a write was dropped while full
//   tx_data           byte presented to the transmitter (held until the next pop)
//   tx_start          one-cycle start pulse, issued in LOAD
//   tx_busy           transmitter busy, high while a frame is being shifted out
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy
);

  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;
  localparam logic [ADDR_W:0]   CNT_DEPTH = DEPTH;
  localparam logic [TMR_W-1:0]  TMR_ONE   = 1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = BUSY_TIMEOUT - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TMR_W-1:0]  timer;
  logic [TMR_W-1:0]  timer_nxt;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              pop;
  logic              wr_acc;

  // A flush cycle suppresses the pop so the flushed head byte is never launched.
  assign pop = (state == IDLE) && !empty && !tx_busy && !flush;

  // When full, a write only fits if the head leaves in the same cycle.
  assign wr_acc = wr_en && !flush && (!full || pop);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Storage array carries no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
    end else if (flush) begin
      // tx_data is left alone so an in-flight byte keeps its data stable.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_DEPTH);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    tx_start  = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        tx_start  = 1'b1;
        timer_nxt = '0;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        // A transmitter that never acknowledges must not wedge the queue:
        // after BUSY_TIMEOUT cycles the byte is treated as sent.
        if (tx_busy) begin
          state_nxt = WAIT_LO;
        end else if (timer == TMR_LAST) begin
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TMR_ONE;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
